// File: rtl/snake_engine_if.sv
// Control, query and status bundle between the snake engine and its host
// (tick source, input decoder, pixel pipeline).
interface snake_engine_if #(
  parameter int XW = 5,
  parameter int YW = 5,
  parameter int LW = 8
) ();
  logic          tick, start, pause, dir_req_valid;
  logic [1:0]    dir_req;
  logic [XW-1:0] qry_x;
  logic [YW-1:0] qry_y;
  logic          qry_snake, qry_head, qry_food;
  logic [XW-1:0] food_x;
  logic [YW-1:0] food_y;
  logic [LW-1:0] snake_len;
  logic [15:0]   score;
  logic [1:0]    state;
  logic          game_over;

  modport master (
    output tick, start, pause, dir_req_valid, dir_req, qry_x, qry_y,
    input  qry_snake, qry_head, qry_food, food_x, food_y, snake_len, score, state, game_over
  );
  modport slave (
    input  tick, start, pause, dir_req_valid, dir_req, qry_x, qry_y,
    output qry_snake, qry_head, qry_food, food_x, food_y, snake_len, score, state, game_over
  );
endinterface

// File: rtl/snake_engine.sv
// Snake game engine: tick-stepped body/food/score state with a registered
// cell-query port for the pixel pipeline.
module snake_engine #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 18,
  parameter int XW       = 5,
  parameter int YW       = 5,
  parameter int MAX_LEN  = 128,
  parameter int INIT_LEN = 4,
  parameter int LW       = 8,
  parameter int WRAP     = 1
) (
  input logic           video_clk,
  input logic           rst_n,
  snake_engine_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PLACE = 2'd2, OVER = 2'd3} state_e;
  localparam logic [1:0] UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3;

  function automatic logic [XW-1:0] init_x(input int i);
    return (i < INIT_LEN) ? XW'(GRID_W/2 - i) : '0;
  endfunction

  state_e        st, st_n;
  logic [XW-1:0] seg_x [MAX_LEN];
  logic [YW-1:0] seg_y [MAX_LEN];
  logic [LW-1:0] len;
  logic [15:0]   score, lfsr;
  logic [1:0]    dir, pend_dir;
  logic          pend_step, over;
  logic [XW-1:0] food_x, cand_x, nx;
  logic [YW-1:0] food_y, cand_y, ny;
  logic          step, reinit, oob, grow, hit, dead, cand_ok;
  logic          q_in, q_snake, q_snake_r, q_head_r, q_food_r;

  assign step   = (st == RUN) && (bus.tick || pend_step) && !bus.pause;
  assign reinit = (st == OVER) && bus.start;
  assign cand_x = lfsr[XW-1:0];
  assign cand_y = lfsr[XW+YW-1:XW];
  assign q_in   = (int'(bus.qry_x) < GRID_W) && (int'(bus.qry_y) < GRID_H);

  // Next head cell; oob flags an edge crossing (wrapped value used only when WRAP=1)
  always_comb begin
    nx  = seg_x[0];
    ny  = seg_y[0];
    oob = 1'b0;
    case (pend_dir)
      UP:      if (seg_y[0] == '0) begin ny = YW'(GRID_H-1); oob = 1'b1; end
               else ny = seg_y[0] - YW'(1);
      DOWN:    if (int'(seg_y[0]) == GRID_H-1) begin ny = '0; oob = 1'b1; end
               else ny = seg_y[0] + YW'(1);
      LEFT:    if (seg_x[0] == '0) begin nx = XW'(GRID_W-1); oob = 1'b1; end
               else nx = seg_x[0] - XW'(1);
      default: if (int'(seg_x[0]) == GRID_W-1) begin nx = '0; oob = 1'b1; end
               else nx = seg_x[0] + XW'(1);
    endcase
  end

  // The tail only counts as an obstacle when it stays put (growth step)
  always_comb begin
    grow    = (nx == food_x) && (ny == food_y);
    hit     = 1'b0;
    cand_ok = (int'(cand_x) < GRID_W) && (int'(cand_y) < GRID_H);
    q_snake = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LW'(i) < len) begin
        if (seg_x[i] == cand_x && seg_y[i] == cand_y) cand_ok = 1'b0;
        if (seg_x[i] == bus.qry_x && seg_y[i] == bus.qry_y) q_snake = 1'b1;
        if (seg_x[i] == nx && seg_y[i] == ny && (grow || LW'(i) < len - LW'(1))) hit = 1'b1;
      end
    end
    dead = (oob && (WRAP == 0)) || hit;
  end

  always_comb begin
    st_n = st;
    case (st)
      IDLE:    if (bus.start) st_n = RUN;
      RUN:     if (step) st_n = dead ? OVER : (grow ? PLACE : RUN);
      PLACE:   if (cand_ok) st_n = RUN;
      default: if (bus.start) st_n = RUN;
    endcase
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= IDLE;
      over <= 1'b0;
    end else begin
      st   <= st_n;
      over <= (st_n == OVER);
    end
  end

  // Free-running; deliberately untouched by a restart so each game differs
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= init_x(i);
        seg_y[i] <= YW'(GRID_H/2);
      end
      len       <= LW'(INIT_LEN);
      score     <= '0;
      dir       <= RIGHT;
      pend_dir  <= RIGHT;
      pend_step <= 1'b0;
      food_x    <= XW'(GRID_W-4);
      food_y    <= YW'(GRID_H/3);
    end else if (reinit) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= init_x(i);
        seg_y[i] <= YW'(GRID_H/2);
      end
      len       <= LW'(INIT_LEN);
      score     <= '0;
      dir       <= RIGHT;
      pend_dir  <= RIGHT;
      pend_step <= 1'b0;
      food_x    <= XW'(GRID_W-4);
      food_y    <= YW'(GRID_H/3);
    end else begin
      if (bus.dir_req_valid && bus.dir_req != (dir ^ 2'b01)) pend_dir <= bus.dir_req;
      if (st == PLACE && bus.tick) pend_step <= 1'b1;
      if (st == PLACE && cand_ok) begin
        food_x <= cand_x;
        food_y <= cand_y;
      end
      if (step) begin
        pend_step <= 1'b0;
        dir       <= pend_dir;
        if (!dead) begin
          // Full-depth shift: index len picks up the old tail for growth
          seg_x[0] <= nx;
          seg_y[0] <= ny;
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          if (grow) begin
            if (len != LW'(MAX_LEN)) len <= len + LW'(1);
            if (score != 16'hFFFF)   score <= score + 16'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      q_snake_r <= 1'b0;
      q_head_r  <= 1'b0;
      q_food_r  <= 1'b0;
    end else begin
      q_snake_r <= q_in && q_snake;
      q_head_r  <= q_in && (bus.qry_x == seg_x[0]) && (bus.qry_y == seg_y[0]);
      q_food_r  <= q_in && (bus.qry_x == food_x) && (bus.qry_y == food_y);
    end
  end

  assign bus.qry_snake = q_snake_r;
  assign bus.qry_head  = q_head_r;
  assign bus.qry_food  = q_food_r;
  assign bus.food_x    = food_x;
  assign bus.food_y    = food_y;
  assign bus.snake_len = len;
  assign bus.score     = score;
  assign bus.state     = st;
  assign bus.game_over = over;
endmodule
